// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: decode/execute hazard inputs and per-stage register controls.
// Optional perf counters (HAZARD_PERF_EN) travel on the same bundle.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_branch_taken;
    logic              ex_is_mul;
    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_we;
    logic              idex_flush;
    logic              exmem_we;
    logic              exmem_flush;
    logic              memwb_we;
    logic              memwb_flush;
    logic              mul_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0]       perf_stall_cyc;
    logic [31:0]       perf_flush_evt;
`endif

    modport master (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, ex_is_mul,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, exmem_flush, memwb_we, memwb_flush, mul_busy
`ifdef HAZARD_PERF_EN
        , output perf_stall_cyc, perf_flush_evt
`endif
    );

    modport slave (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               ex_branch_taken, ex_is_mul,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, exmem_flush, memwb_we, memwb_flush, mul_busy
`ifdef HAZARD_PERF_EN
        , input perf_stall_cyc, perf_flush_evt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX branch flush, multi-cycle multiply hold.
// Controls are combinational from state+inputs; HAZARD_PERF_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    pipe_hazard_ctrl_if.master hz
);
    localparam int CW = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef enum logic {RUN, MUL_WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
    logic exmem_we, exmem_flush, memwb_we, memwb_flush, mul_busy;
    logic load_use, branch_flush;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != ZERO_REG) &&
                      ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_flush   = 1'b0;
        exmem_we     = 1'b1;
        exmem_flush  = 1'b0;
        memwb_we     = 1'b1;
        memwb_flush  = 1'b0;
        mul_busy     = 1'b0;
        branch_flush = 1'b0;
        if (Rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_we     = 1'b0;
            idex_flush  = 1'b1;
            exmem_we    = 1'b0;
            exmem_flush = 1'b1;
            memwb_we    = 1'b0;
            memwb_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hz.ex_is_mul && (MUL_LAT > 1)) begin
                        // Hold IF/ID/EX, send a bubble into MEM, let WB drain.
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_we     = 1'b0;
                        exmem_flush = 1'b1;
                        state_nxt   = MUL_WAIT;
                        cnt_nxt     = CNT_LOAD;
                    end else if (hz.ex_branch_taken) begin
                        // ID holds a wrong-path instruction, so any load-use match is moot.
                        branch_flush = 1'b1;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                    end else if (load_use) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    mul_busy = 1'b1;
                    if (cnt != '0) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_we     = 1'b0;
                        exmem_flush = 1'b1;
                        cnt_nxt     = cnt - 1'b1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign hz.pc_we       = pc_we;
    assign hz.ifid_we     = ifid_we;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_we     = idex_we;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_we    = exmem_we;
    assign hz.exmem_flush = exmem_flush;
    assign hz.memwb_we    = memwb_we;
    assign hz.memwb_flush = memwb_flush;
    assign hz.mul_busy    = mul_busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_evt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            perf_stall_cyc <= '0;
            perf_flush_evt <= '0;
        end else begin
            if (!pc_we && (perf_stall_cyc != 32'hFFFF_FFFF))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (branch_flush && (perf_flush_evt != 32'hFFFF_FFFF))
                perf_flush_evt <= perf_flush_evt + 32'd1;
        end
    end

    assign hz.perf_stall_cyc = perf_stall_cyc;
    assign hz.perf_flush_evt = perf_flush_evt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, multiply corner sequences, random vs reference model.
module tb_pipe_hazard_ctrl;
    localparam logic [9:0] DEF = 10'b1101010100;
    localparam logic [9:0] RST = 10'b0010101010;
    localparam logic [9:0] LU  = 10'b0001110100;
    localparam logic [9:0] BR  = 10'b1111110100;
    localparam logic [9:0] MUL = 10'b0000011100;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       mul;
    } in_t;

    typedef struct packed {
        logic       rst;
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl_if #(.REG_AW(5)) if4 ();
    pipe_hazard_ctrl_if #(.REG_AW(5)) if1 ();

    pipe_hazard_ctrl #(.REG_AW(5), .MUL_LAT(4)) dut4 (.Clk(Clk), .Rst(Rst), .hz(if4.master));
    pipe_hazard_ctrl #(.REG_AW(5), .MUL_LAT(1)) dut1 (.Clk(Clk), .Rst(Rst), .hz(if1.master));

    function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                               logic mr, logic [4:0] rd, logic br, logic mul);
        in_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.mr = mr; v.rd = rd; v.br = br; v.mul = mul;
        return v;
    endfunction

    // Reference: left = EX cycles still owed by an in-flight multiply after its detect cycle.
    function automatic logic [9:0] model_out(int lat, int left, logic r, in_t in);
        logic lu;
        int   k;
        if (r) return RST;
        if (left > 0) begin
            k = lat - left + 1;
            return ((k < lat) ? MUL : DEF) | 10'b1;
        end
        if (in.mul && lat > 1) return MUL;
        if (in.br) return BR;
        lu = in.mr && (in.rd != 5'd0) &&
             ((in.urs && in.rs == in.rd) || (in.urt && in.rt == in.rd));
        return lu ? LU : DEF;
    endfunction

    function automatic int model_next(int lat, int left, logic r, in_t in);
        if (r) return 0;
        if (left > 0) return left - 1;
        if (in.mul && lat > 1) return lat - 1;
        return 0;
    endfunction

    task automatic drive(logic r, in_t in);
        Rst = r;
        if4.id_rs = in.rs; if4.id_rt = in.rt; if4.id_uses_rs = in.urs; if4.id_uses_rt = in.urt;
        if4.ex_mem_read = in.mr; if4.ex_rd = in.rd; if4.ex_branch_taken = in.br; if4.ex_is_mul = in.mul;
        if1.id_rs = in.rs; if1.id_rt = in.rt; if1.id_uses_rs = in.urs; if1.id_uses_rt = in.urt;
        if1.ex_mem_read = in.mr; if1.ex_rd = in.rd; if1.ex_branch_taken = in.br; if1.ex_is_mul = in.mul;
    endtask

    // Apply inputs just after a rising edge, sample mid-cycle, then advance one clock.
    task automatic step(logic r, in_t in, output logic [9:0] o4, output logic [9:0] o1);
        drive(r, in);
        #4;
        o4 = {if4.pc_we, if4.ifid_we, if4.ifid_flush, if4.idex_we, if4.idex_flush,
              if4.exmem_we, if4.exmem_flush, if4.memwb_we, if4.memwb_flush, if4.mul_busy};
        o1 = {if1.pc_we, if1.ifid_we, if1.ifid_flush, if1.idex_we, if1.idex_flush,
              if1.exmem_we, if1.exmem_flush, if1.memwb_we, if1.memwb_flush, if1.mul_busy};
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t tbl [18];
    in_t  idle;
    in_t  ri;
    logic [9:0] o4, o1;
    int   left4, left1;
    logic rr, prev_mul;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = '{1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1), RST};
        tbl[1]  = '{1'b0, idle, DEF};
        tbl[2]  = '{1'b0, mk(5, 0, 1, 0, 1, 5, 0, 0), LU};
        tbl[3]  = '{1'b0, mk(0, 0, 1, 0, 1, 0, 0, 0), DEF};
        tbl[4]  = '{1'b0, mk(3, 7, 0, 1, 1, 7, 0, 0), LU};
        tbl[5]  = '{1'b0, mk(5, 0, 0, 0, 1, 5, 0, 0), DEF};
        tbl[6]  = '{1'b0, mk(5, 0, 1, 0, 1, 5, 1, 0), BR};
        tbl[7]  = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1), MUL};
        tbl[8]  = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1), MUL | 10'b1};
        tbl[9]  = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1), MUL | 10'b1};
        tbl[10] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1), DEF | 10'b1};
        tbl[11] = '{1'b0, idle, DEF};
        tbl[12] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 1, 1), MUL};
        tbl[13] = '{1'b0, mk(4, 0, 1, 0, 1, 4, 1, 1), MUL | 10'b1};
        tbl[14] = '{1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1), RST};
        tbl[15] = '{1'b0, idle, DEF};
        tbl[16] = '{1'b0, mk(2, 0, 1, 0, 1, 2, 0, 0), LU};
        tbl[17] = '{1'b0, idle, DEF};

        drive(1'b1, idle);
        @(posedge Clk);
        #1;
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].in, o4, o1);
            chk($sformatf("vec%0d", i), 32'(o4), 32'(tbl[i].exp));
        end

        // Randomised phase, both latencies against the reference model.
        step(1'b1, idle, o4, o1);
        left4 = 0; left1 = 0; prev_mul = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 59) == 0);
            ri.rs  = 5'($urandom_range(0, 3));
            ri.rt  = 5'($urandom_range(0, 3));
            ri.urs = 1'($urandom_range(0, 1));
            ri.urt = 1'($urandom_range(0, 1));
            ri.mr  = 1'($urandom_range(0, 1));
            ri.rd  = 5'($urandom_range(0, 3));
            ri.br  = ($urandom_range(0, 4) == 0);
            ri.mul = ($urandom_range(0, 5) == 0) || (prev_mul && $urandom_range(0, 3) != 0);
            prev_mul = ri.mul;
            step(rr, ri, o4, o1);
            chk($sformatf("rnd4_%0d", n), 32'(o4), 32'(model_out(4, left4, rr, ri)));
            chk($sformatf("rnd1_%0d", n), 32'(o1), 32'(model_out(1, left1, rr, ri)));
            left4 = model_next(4, left4, rr, ri);
            left1 = model_next(1, left1, rr, ri);
        end

        // One load-use, one branch, one full multiply; MUL_LAT=1 never stalls on it.
        step(1'b1, idle, o4, o1);
        chk("seq_rst", 32'(o4), 32'(RST));
        step(1'b0, mk(1, 0, 1, 0, 1, 1, 0, 0), o4, o1);
        chk("seq_lu", 32'(o4), 32'(LU));
        step(1'b0, mk(0, 0, 0, 0, 0, 0, 1, 0), o4, o1);
        chk("seq_br", 32'(o4), 32'(BR));
        for (int c = 0; c < 4; c++) begin
            step(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1), o4, o1);
            chk($sformatf("seq_mul4_c%0d", c + 1), 32'(o4),
                32'((c < 3 ? MUL : DEF) | ((c > 0) ? 10'b1 : 10'b0)));
            chk($sformatf("seq_mul1_c%0d", c + 1), 32'(o1), 32'(DEF));
        end
        step(1'b0, idle, o4, o1);
        chk("seq_idle", 32'(o4), 32'(DEF));
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cyc", if4.perf_stall_cyc, 32'd4);
        chk("perf_flush_evt", if4.perf_flush_evt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
